// File: rtl/spi_xfer_sequencer.sv
// rtl/spi_xfer_sequencer.sv - TX/RX byte sequencer driving spi_module transfers
// Optional SS-wait timeout enabled by defining SPI_SEQ_TIMEOUT_EN.

module spi_xfer_seq_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module spi_xfer_sequencer #(
  parameter int FIFO_DEPTH  = 8,
  parameter int GAP_CYC     = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic        i_sys_clk,
  input  logic        i_sys_rst,
  input  logic [31:0] i_cfg_word,
  input  logic        i_tx_valid,
  input  logic [7:0]  i_tx_data,
  output logic        o_tx_ready,
  output logic        o_rx_valid,
  output logic [7:0]  o_rx_data,
  input  logic        i_rx_ready,
  output logic [31:0] o_data_config,
  output logic [7:0]  o_data,
  output logic        o_trans_en,
  input  logic [7:0]  i_spi_data,
  input  logic        i_ss,
  input  logic        i_spi_irq,
  output logic        o_busy,
  output logic        o_err,
  input  logic        i_err_clr
);
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_WAIT_LOW, S_WAIT_HIGH, S_CAPTURE, S_GAP
  } state_t;

  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

  state_t state;
  state_t state_nxt;

  logic [7:0]       tx_head;
  logic             tx_full;
  logic             tx_empty;
  logic             tx_pop;
  logic [7:0]       rx_head;
  logic             rx_full;
  logic             rx_empty;
  logic             rx_push;
  logic             load_data;
  logic             te_set;
  logic             te_clr;
  logic             err_set;
  logic             abort;
  logic             timeout_hit;
  logic [GAP_W-1:0] gap_cnt;
  logic             ss_m;
  logic             ss_s;
  logic             ss_q;

  spi_xfer_seq_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
    .clk       (i_sys_clk),
    .rst       (i_sys_rst),
    .push      (i_tx_valid & o_tx_ready),
    .push_data (i_tx_data),
    .pop       (tx_pop),
    .head      (tx_head),
    .full      (tx_full),
    .empty     (tx_empty)
  );

  spi_xfer_seq_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
    .clk       (i_sys_clk),
    .rst       (i_sys_rst),
    .push      (rx_push),
    .push_data (i_spi_data),
    .pop       (i_rx_ready & o_rx_valid),
    .head      (rx_head),
    .full      (rx_full),
    .empty     (rx_empty)
  );

  // Ready is held low while in reset so nothing is accepted into a flushing FIFO.
  assign o_tx_ready = ~tx_full & ~i_sys_rst;
  assign o_rx_valid = ~rx_empty;
  assign o_rx_data  = rx_empty ? 8'h00 : rx_head;
  assign o_busy     = (state != S_IDLE);

`ifdef SPI_SEQ_TIMEOUT_EN
  localparam int WAIT_W = ($clog2(TIMEOUT_CYC) + 1 > 12) ? $clog2(TIMEOUT_CYC) + 1 : 12;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);
  logic [WAIT_W-1:0] wait_cnt;
  logic              in_wait;

  assign in_wait     = (state == S_WAIT_LOW) || (state == S_WAIT_HIGH);
  assign timeout_hit = in_wait && (wait_cnt == WAIT_LAST);

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      wait_cnt <= '0;
    end else if (!in_wait || (state_nxt != state)) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
  assign timeout_hit = 1'b0;
`endif

  assign abort = i_spi_irq | timeout_hit;

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) state <= S_IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    tx_pop    = 1'b0;
    rx_push   = 1'b0;
    load_data = 1'b0;
    te_set    = 1'b0;
    te_clr    = 1'b0;
    err_set   = 1'b0;
    unique case (state)
      S_IDLE: begin
        // A full RX FIFO holds off the start so a received byte is never dropped.
        if (!tx_empty && !rx_full && !i_spi_irq) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        tx_pop    = 1'b1;
        load_data = 1'b1;
        if (abort) begin
          err_set   = 1'b1;
          state_nxt = S_GAP;
        end else begin
          state_nxt = S_START;
        end
      end
      S_START: begin
        if (abort) begin
          te_clr    = 1'b1;
          err_set   = 1'b1;
          state_nxt = S_GAP;
        end else begin
          te_set    = 1'b1;
          state_nxt = S_WAIT_LOW;
        end
      end
      S_WAIT_LOW: begin
        if (abort) begin
          te_clr    = 1'b1;
          err_set   = 1'b1;
          state_nxt = S_GAP;
        end else if (!ss_s) begin
          te_clr    = 1'b1;
          state_nxt = S_WAIT_HIGH;
        end
      end
      S_WAIT_HIGH: begin
        if (abort) begin
          te_clr    = 1'b1;
          err_set   = 1'b1;
          state_nxt = S_GAP;
        end else if (ss_s && !ss_q) begin
          state_nxt = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        rx_push   = 1'b1;
        state_nxt = S_GAP;
      end
      S_GAP: begin
        if (gap_cnt == GAP_LAST) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      o_data_config <= '0;
      o_data        <= '0;
      o_trans_en    <= 1'b0;
      o_err         <= 1'b0;
      gap_cnt       <= '0;
      ss_m          <= 1'b1;
      ss_s          <= 1'b1;
      ss_q          <= 1'b1;
    end else begin
      ss_m <= i_ss;
      ss_s <= ss_m;
      ss_q <= ss_s;
      // spi_module faults on a config change mid-transfer, so only track it when idle.
      if (state == S_IDLE) o_data_config <= i_cfg_word;
      if (load_data) o_data <= tx_head;
      if (te_set)      o_trans_en <= 1'b1;
      else if (te_clr) o_trans_en <= 1'b0;
      if (err_set)        o_err <= 1'b1;
      else if (i_err_clr) o_err <= 1'b0;
      gap_cnt <= (state == S_GAP) ? gap_cnt + 1'b1 : '0;
    end
  end
endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// tb/tb_spi_xfer_sequencer.sv - directed bench for spi_xfer_sequencer with an SS/spi_module model
module tb_spi_xfer_sequencer;
  localparam int FIFO_DEPTH  = 8;
  localparam int GAP_CYC     = 4;
  localparam int TIMEOUT_CYC = 64;
  localparam int SS_LOW_LEN  = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] cfg_word = 32'h0;
  logic        tx_valid = 1'b0;
  logic [7:0]  tx_data = 8'h00;
  logic        tx_ready;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready = 1'b0;
  logic [31:0] data_config;
  logic [7:0]  data;
  logic        trans_en;
  logic [7:0]  spi_data = 8'h00;
  logic        ss_line = 1'b1;
  logic        spi_irq = 1'b0;
  logic        busy;
  logic        err;
  logic        err_clr = 1'b0;

  always #5 clk = ~clk;

  spi_xfer_sequencer #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .GAP_CYC    (GAP_CYC),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .i_sys_clk    (clk),
    .i_sys_rst    (rst),
    .i_cfg_word   (cfg_word),
    .i_tx_valid   (tx_valid),
    .i_tx_data    (tx_data),
    .o_tx_ready   (tx_ready),
    .o_rx_valid   (rx_valid),
    .o_rx_data    (rx_data),
    .i_rx_ready   (rx_ready),
    .o_data_config(data_config),
    .o_data       (data),
    .o_trans_en   (trans_en),
    .i_spi_data   (spi_data),
    .i_ss         (ss_line),
    .i_spi_irq    (spi_irq),
    .o_busy       (busy),
    .o_err        (err),
    .i_err_clr    (err_clr)
  );

  typedef struct {
    logic [7:0] tx;
    logic [7:0] resp;
    logic [7:0] exp_rx;
  } vec_t;
  vec_t vecs [8];

  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  logic [7:0] resp_q [$];
  int         start_cyc_q [$];
  logic [7:0] start_data_q [$];
  int         ss_rise_q [$];
  logic       model_en = 1'b1;
  logic       model_active = 1'b0;
  logic       te_prev = 1'b0;
  logic       ss_prev = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  // spi_module stand-in: SS low 2 clocks after trans_en, high SS_LOW_LEN clocks later
  initial begin
    forever begin
      @(negedge clk);
      if (model_en && trans_en && ss_line) begin
        model_active = 1'b1;
        repeat (2) @(negedge clk);
        ss_line = 1'b0;
        if (resp_q.size() > 0) spi_data = resp_q.pop_front();
        repeat (SS_LOW_LEN) @(negedge clk);
        ss_line = 1'b1;
        model_active = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (trans_en && !te_prev) begin
      start_cyc_q.push_back(cyc);
      start_data_q.push_back(data);
    end
    if (ss_line && !ss_prev) ss_rise_q.push_back(cyc);
    te_prev = trans_en;
    ss_prev = ss_line;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, n_tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] d, input logic [7:0] resp, inout bit blocked);
    int k = 0;
    while (!tx_ready && k < 2000) begin
      blocked = 1'b1;
      @(negedge clk);
      k++;
    end
    if (!tx_ready) check("push_ready_timeout", tx_ready, 1);
    tx_valid = 1'b1;
    tx_data  = d;
    resp_q.push_back(resp);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_rx(input int lim, input string name);
    int k = 0;
    while (!rx_valid && k < lim) begin
      @(negedge clk);
      k++;
    end
    check(name, rx_valid, 1);
  endtask

  task automatic wait_te(input logic lvl, input int lim, input string name);
    int k = 0;
    while (trans_en !== lvl && k < lim) begin
      @(negedge clk);
      k++;
    end
    check(name, trans_en, lvl);
  endtask

  task automatic wait_model_idle();
    int k = 0;
    while (model_active && k < 200) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic pop_rx();
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  initial begin
    bit blk;
    logic [7:0] b;
    vecs[0] = '{tx: 8'h01, resp: 8'h11, exp_rx: 8'h11};
    vecs[1] = '{tx: 8'h02, resp: 8'h22, exp_rx: 8'h22};
    vecs[2] = '{tx: 8'h03, resp: 8'hF0, exp_rx: 8'hF0};
    vecs[3] = '{tx: 8'h04, resp: 8'h0F, exp_rx: 8'h0F};
    vecs[4] = '{tx: 8'h05, resp: 8'h00, exp_rx: 8'h00};
    vecs[5] = '{tx: 8'h06, resp: 8'hFF, exp_rx: 8'hFF};
    vecs[6] = '{tx: 8'h07, resp: 8'hA5, exp_rx: 8'hA5};
    vecs[7] = '{tx: 8'h08, resp: 8'h5A, exp_rx: 8'h5A};

    // reset state
    cfg_word = 32'h1234_5678;
    #1;
    check("rst_trans_en", trans_en, 0);
    check("rst_busy", busy, 0);
    check("rst_data_config", data_config, 0);
    check("rst_data", data, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_err", err, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_rel_config", data_config, 32'h1234_5678);
    check("rst_rel_tx_ready", tx_ready, 1);
    check("rst_rel_busy", busy, 0);

    // single byte: latency, frozen config, gap
    blk = 1'b0;
    push_byte(8'hA5, 8'h3C, blk);
    check("t1_busy_push", busy, 0);
    @(negedge clk);
    check("t1_busy_load", busy, 1);
    check("t1_te_load", trans_en, 0);
    cfg_word = 32'hDEAD_BEEF;
    @(negedge clk);
    check("t1_te_start", trans_en, 0);
    check("t1_data", data, 8'hA5);
    @(negedge clk);
    check("t1_te_rise", trans_en, 1);
    check("t1_config_frozen", data_config, 32'h1234_5678);
    wait_rx(200, "t1_rx_valid");
    check("t1_rx_data", rx_data, 8'h3C);
    check("t1_busy_gap0", busy, 1);
    repeat (GAP_CYC - 1) @(negedge clk);
    check("t1_busy_gap_end", busy, 1);
    @(negedge clk);
    check("t1_busy_idle", busy, 0);
    @(negedge clk);
    check("t1_config_reload", data_config, 32'hDEAD_BEEF);
    pop_rx();
    check("t1_rx_empty", rx_valid, 0);

    // burst of 8 from the vector table
    start_cyc_q.delete(); start_data_q.delete(); ss_rise_q.delete();
    blk = 1'b0;
    for (int i = 0; i < 8; i++) push_byte(vecs[i].tx, vecs[i].resp, blk);
    check("t2_tx_ready_held", blk, 0);
    for (int i = 0; i < 8; i++) begin
      wait_rx(400, "t2_rx_valid");
      check("t2_rx_data", rx_data, vecs[i].exp_rx);
      pop_rx();
    end
    check("t2_starts", start_data_q.size(), 8);
    for (int i = 0; i < 8 && i < start_data_q.size(); i++) begin
      check("t2_tx_order", start_data_q[i], vecs[i].tx);
      if (i >= 1 && i - 1 < ss_rise_q.size())
        check("t2_gap_ok", (start_cyc_q[i] - ss_rise_q[i-1]) >= GAP_CYC, 1);
    end

    // RX back-pressure
    start_cyc_q.delete(); start_data_q.delete(); ss_rise_q.delete();
    rx_ready = 1'b0;
    blk = 1'b0;
    for (int i = 0; i < 10; i++) begin
      b = 8'h80 + 8'(i);
      push_byte(8'hB0 + 8'(i), b, blk);
    end
    check("t3_tx_full_seen", blk, 1);
    repeat (600) @(negedge clk);
    check("t3_starts_stall", start_cyc_q.size(), FIFO_DEPTH);
    check("t3_busy_stall", busy, 0);
    check("t3_rx_head", rx_data, 8'h80);
    pop_rx();
    repeat (150) @(negedge clk);
    check("t3_starts_release", start_cyc_q.size(), FIFO_DEPTH + 1);
    for (int i = 1; i < 10; i++) begin
      wait_rx(400, "t3_rx_valid");
      b = 8'h80 + 8'(i);
      check("t3_rx_order", rx_data, b);
      pop_rx();
    end
    check("t3_starts_total", start_cyc_q.size(), 10);

    // abort during WAIT_HIGH; set beats clear in the same cycle
    push_byte(8'h55, 8'h66, blk);
    wait_te(1, 50, "t4_te_rise");
    wait_te(0, 50, "t4_te_fall");
    repeat (3) @(negedge clk);
    spi_irq = 1'b1;
    err_clr = 1'b1;
    @(negedge clk);
    spi_irq = 1'b0;
    err_clr = 1'b0;
    check("t4_err_set", err, 1);
    check("t4_te_abort", trans_en, 0);
    check("t4_busy_gap", busy, 1);
    wait_model_idle();
    repeat (20) @(negedge clk);
    check("t4_no_rx_push", rx_valid, 0);
    check("t4_err_sticky", err, 1);
    check("t4_idle", busy, 0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("t4_err_clr", err, 0);
    push_byte(8'h77, 8'h88, blk);
    wait_rx(200, "t4_next_rx_valid");
    check("t4_next_rx_data", rx_data, 8'h88);
    pop_rx();

    // SS never goes low
    model_en = 1'b0;
    push_byte(8'h99, 8'h00, blk);
    wait_te(1, 50, "t5_te_rise");
`ifdef SPI_SEQ_TIMEOUT_EN
    repeat (TIMEOUT_CYC - 1) @(negedge clk);
    check("t5_err_before", err, 0);
    check("t5_te_before", trans_en, 1);
    @(negedge clk);
    check("t5_err_timeout", err, 1);
    check("t5_te_timeout", trans_en, 0);
    repeat (GAP_CYC + 2) @(negedge clk);
    check("t5_idle", busy, 0);
    check("t5_no_rx", rx_valid, 0);
`else
    repeat (200) @(negedge clk);
    check("t5_te_held", trans_en, 1);
    check("t5_busy_held", busy, 1);
    check("t5_no_err", err, 0);
`endif
    #3 rst = 1'b1;
    #1;
    check("t5_rst_te", trans_en, 0);
    check("t5_rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    model_en = 1'b1;
    resp_q.delete();
    @(negedge clk);
    check("t5_rel_err", err, 0);

    // async reset mid-WAIT_HIGH with data in both FIFOs
    cfg_word = 32'hC0FF_EE11;
    rx_ready = 1'b0;
    push_byte(8'h10, 8'h20, blk);
    wait_rx(200, "t6_rx_valid");
    push_byte(8'h30, 8'h40, blk);
    push_byte(8'h50, 8'h60, blk);
    wait_te(1, 200, "t6_te_rise");
    wait_te(0, 50, "t6_te_fall");
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_busy", busy, 0);
    check("t6_rst_te", trans_en, 0);
    check("t6_rst_data", data, 0);
    check("t6_rst_config", data_config, 0);
    check("t6_rst_rx_valid", rx_valid, 0);
    check("t6_rst_rx_data", rx_data, 0);
    check("t6_rst_tx_ready", tx_ready, 0);
    wait_model_idle();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    resp_q.delete();
    @(negedge clk);
    check("t6_rel_config", data_config, 32'hC0FF_EE11);
    check("t6_rel_tx_ready", tx_ready, 1);
    repeat (20) @(negedge clk);
    check("t6_tx_flushed", busy, 0);
    check("t6_rx_flushed", rx_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
